// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480), test-pattern mode encodings and bar colours.
package vga_pkg;

    localparam int HBLANK  = 160;
    localparam int HPERIOD = 800;
    localparam int VBLANK  = 45;
    localparam int VPERIOD = 525;

    typedef enum logic [1:0] {
        PM_GRAD   = 2'd0,
        PM_BARS   = 2'd1,
        PM_CHECK  = 2'd2,
        PM_SCROLL = 2'd3
    } pmode_t;

    // {R,G,B} enables, left to right across the screen
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/test_pattern_gen_if.sv
// Raster-position inputs, mode request and RGB/DE outputs of the pattern generator.
interface test_pattern_gen_if #(
    parameter int CW = 4,
    parameter int HW = 10
);
    logic [HW-1:0] HCNT;
    logic [HW-1:0] VCNT;
    logic [1:0]    MODE;
    logic [CW-1:0] VGA_R;
    logic [CW-1:0] VGA_G;
    logic [CW-1:0] VGA_B;
    logic          DE;

    modport master (output HCNT, VCNT, MODE, input VGA_R, VGA_G, VGA_B, DE);
    modport slave  (input HCNT, VCNT, MODE, output VGA_R, VGA_G, VGA_B, DE);
endinterface

// File: rtl/pg_wrapcnt.sv
// Wrap counter with a saturating index; clr forces both to zero in the same cycle.
// Latency: idx is combinational from clr, registered otherwise.
// Backpressure: none, advances whenever en is high.
module pg_wrapcnt #(
    parameter int CNTW = 10,
    parameter int IDXW = 3,
    parameter int WRAP = 80,
    parameter int IMAX = 7
) (
    input  logic            PCK,
    input  logic            RST,
    input  logic            clr,
    input  logic            en,
    output logic [IDXW-1:0] idx
);
    localparam logic [CNTW-1:0] CLAST = CNTW'(WRAP - 1);
    localparam logic [IDXW-1:0] ILAST = IDXW'(IMAX);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt;
    logic [IDXW-1:0] idx_q;

    assign cnt = clr ? '0 : cnt_q;
    assign idx = clr ? '0 : idx_q;

    always_ff @(posedge PCK) begin
        if (RST) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (en) begin
            if (cnt == CLAST) begin
                cnt_q <= '0;
                idx_q <= (idx == ILAST) ? idx : idx + 1'b1;
            end else begin
                cnt_q <= cnt + 1'b1;
                idx_q <= idx;
            end
        end else if (clr) begin
            cnt_q <= '0;
            idx_q <= '0;
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// VGA test-pattern generator: gradation bands, colour bars, checkerboard, scrolling gradation.
// Latency: RGB/DE registered, one PCK after the HCNT/VCNT they belong to.
// Backpressure: none; mode and scroll offset only change at frame start.
module test_pattern_gen #(
    parameter int CW        = 4,
    parameter int HW        = 10,
    parameter int HBLANK    = vga_pkg::HBLANK,
    parameter int HPERIOD   = vga_pkg::HPERIOD,
    parameter int VBLANK    = vga_pkg::VBLANK,
    parameter int VSIZE     = 120,
    parameter int NBAND     = 4,
    parameter int STEP_LOG2 = 2,
    parameter int BARW      = 80,
    parameter int CHK_LOG2  = 5,
    parameter int SPEED     = 1
) (
    input  logic                  PCK,
    input  logic                  RST,
    test_pattern_gen_if.slave     pg
);
    import vga_pkg::*;

    localparam int              BW      = $clog2(NBAND + 1);
    localparam logic [HW-1:0]   H_FIRST = HW'(HBLANK - 1);
    localparam logic [HW-1:0]   H_LAST  = HW'(HPERIOD - 1);
    localparam logic [HW-1:0]   V_FIRST = HW'(VBLANK);
    localparam logic [CW-1:0]   FULL    = '1;

    pmode_t        mode_q;
    logic [HW-1:0] ofs;
    logic [HW-1:0] x;
    logic [HW-1:0] g;
    logic          act;
    logic          line_start;
    logic          frame_start;
    logic          y_chk;
    logic [BW-1:0] band;
    logic [2:0]    bar;
    logic [2:0]    bar_en;
    logic [CW-1:0] lvl;
    logic [CW-1:0] r_d, g_d, b_d;
    logic [CW-1:0] r_q, g_q, b_q;
    logic          de_q;

    // Active window starts one count early so the registered pixel lands on HBLANK.
    assign act         = (pg.HCNT >= H_FIRST) && (pg.HCNT < H_LAST) && (pg.VCNT >= V_FIRST);
    assign line_start  = (pg.HCNT == '0);
    assign frame_start = line_start && (pg.VCNT == '0);
    assign x           = pg.HCNT - H_FIRST;
    assign y_chk       = 1'((pg.VCNT - V_FIRST) >> CHK_LOG2);
    assign g           = (mode_q == PM_SCROLL) ? x + ofs : x;
    assign lvl         = CW'(g >> STEP_LOG2);

    pg_wrapcnt #(.CNTW(HW), .IDXW(BW), .WRAP(VSIZE), .IMAX(NBAND)) u_band (
        .PCK (PCK),
        .RST (RST),
        .clr (line_start && (pg.VCNT == V_FIRST)),
        .en  (line_start && (pg.VCNT > V_FIRST)),
        .idx (band)
    );

    pg_wrapcnt #(.CNTW(HW), .IDXW(3), .WRAP(BARW), .IMAX(7)) u_bar (
        .PCK (PCK),
        .RST (RST),
        .clr (x == '0),
        .en  (act),
        .idx (bar)
    );

    always_comb begin
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        bar_en = bar_rgb(bar);
        case (mode_q)
            PM_GRAD, PM_SCROLL: begin
                if (int'(band) < NBAND) begin
                    case (int'(band))
                        0: begin r_d = lvl; g_d = lvl; b_d = lvl; end
                        1: r_d = lvl;
                        2: g_d = lvl;
                        3: b_d = lvl;
                        default: ;
                    endcase
                end
            end
            PM_BARS: begin
                r_d = {CW{bar_en[2]}};
                g_d = {CW{bar_en[1]}};
                b_d = {CW{bar_en[0]}};
            end
            PM_CHECK: begin
                if (x[CHK_LOG2] == y_chk) begin
                    r_d = FULL; g_d = FULL; b_d = FULL;
                end
            end
        endcase
    end

    always_ff @(posedge PCK) begin
        if (RST) begin
            mode_q <= PM_GRAD;
            ofs    <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            de_q   <= 1'b0;
        end else begin
            if (frame_start) begin
                mode_q <= pmode_t'(pg.MODE);
                ofs    <= ofs + HW'(SPEED);
            end
            de_q <= act;
            r_q  <= act ? r_d : '0;
            g_q  <= act ? g_d : '0;
            b_q  <= act ? b_d : '0;
        end
    end

    assign pg.VGA_R = r_q;
    assign pg.VGA_G = g_q;
    assign pg.VGA_B = b_q;
    assign pg.DE    = de_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed frame sequence with random rows/modes, checked against a division-based pixel model.
module tb_test_pattern_gen;

    logic PCK = 1'b0;
    logic RST;
    always #5 PCK = ~PCK;

    test_pattern_gen_if #(.CW(4), .HW(10)) bus();

    test_pattern_gen dut (
        .PCK (PCK),
        .RST (RST),
        .pg  (bus)
    );

    int total;
    int bad;
    int mode_req;
    int mode_m;
    int ofs_m;
    bit band_ok;
    bit bar_ok;

    logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got={de,r,g,b}=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected {DE,R,G,B} for one raster position, from screen coordinates directly.
    task automatic model(input int h, input int v, output logic [12:0] e, output bit known);
        int x, y, gv, lvl, band, bar;
        logic [3:0] l;
        logic [2:0] c;
        e = '0;
        known = 1'b1;
        if (!(h >= 159 && h < 799 && v >= 45)) return;
        x = h - 159;
        y = v - 45;
        case (mode_m)
            0, 3: begin
                gv    = (mode_m == 3) ? (x + ofs_m) % 1024 : x;
                lvl   = (gv / 4) % 16;
                l     = lvl[3:0];
                band  = y / 120;
                known = band_ok;
                case (band)
                    0: e = {1'b1, l, l, l};
                    1: e = {1'b1, l, 4'h0, 4'h0};
                    2: e = {1'b1, 4'h0, l, 4'h0};
                    3: e = {1'b1, 4'h0, 4'h0, l};
                    default: e = {1'b1, 12'h000};
                endcase
            end
            1: begin
                bar = x / 80;
                if (bar > 7) bar = 7;
                c = bars[bar];
                e = {1'b1, {4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
                known = bar_ok;
            end
            default: e = ((((x / 32) + (y / 32)) % 2) == 0) ? {1'b1, 12'hFFF} : {1'b1, 12'h000};
        endcase
    endtask

    task automatic step(input int h, input int v, input bit rst);
        logic [12:0] e;
        logic [12:0] got;
        bit known;
        bus.HCNT = h[9:0];
        bus.VCNT = v[9:0];
        bus.MODE = mode_req[1:0];
        RST      = rst;
        if (!rst && h == 159) bar_ok = 1'b1;
        if (rst) begin
            e = '0;
            known = 1'b1;
        end else begin
            model(h, v, e, known);
        end
        @(posedge PCK);
        #1;
        got = {bus.DE, bus.VGA_R, bus.VGA_G, bus.VGA_B};
        if (known) chk($sformatf("pix_h%0d_v%0d_m%0d", h, v, mode_m), got, e);
        if (!rst) begin
            if (mode_m == 0 && band_ok && h == 179 && v == 45)  chk("grad_grey",  got, 13'h1555);
            if (mode_m == 0 && band_ok && h == 179 && v == 165) chk("grad_red",   got, 13'h1500);
            if (mode_m == 0 && band_ok && h == 179 && v == 524) chk("grad_blue",  got, 13'h1005);
            if (mode_m == 1 && bar_ok && v == 45 && h >= 159 && h <= 238) chk("bar_white", got, 13'h1FFF);
            if (mode_m == 1 && bar_ok && v == 45 && h == 239) chk("bar_yellow", got, 13'h1FF0);
            if (mode_m == 1 && bar_ok && v == 45 && h == 798) chk("bar_black",  got, 13'h1000);
            if (mode_m == 1 && v == 45 && h == 158) chk("bar_preblank", got, 13'h0000);
            if (mode_m == 2 && h == 159 && v == 45) chk("chk_0_0",   got, 13'h1FFF);
            if (mode_m == 2 && h == 191 && v == 45) chk("chk_32_0",  got, 13'h1000);
            if (mode_m == 2 && h == 191 && v == 77) chk("chk_32_32", got, 13'h1FFF);
            if (mode_m == 3 && ofs_m == 3 && band_ok && h == 176 && v == 45) chk("scroll_x17", got, 13'h1555);
        end
        if (rst) begin
            mode_m  = 0;
            ofs_m   = 0;
            band_ok = 1'b0;
            bar_ok  = 1'b0;
        end else begin
            if (h == 0 && v == 0) begin
                mode_m = mode_req;
                ofs_m  = (ofs_m + 1) % 1024;
            end
            if (h == 0 && v == 45) band_ok = 1'b1;
        end
    endtask

    // One frame: every line gets its HCNT==0 visit; listed rows are swept pixel by pixel.
    task automatic run_frame(input int mode, input int mid_mode, input int s0, input int s1,
                             input int s2, input int rst_v);
        mode_req = mode;
        for (int v = 0; v < 525; v++) begin
            if (v == 200 && mid_mode >= 0) mode_req = mid_mode;
            if (v == s0 || v == s1 || v == s2) begin
                for (int h = 0; h < 800; h++) step(h, v, (v == rst_v) && (h == 400));
            end else begin
                step(0, v, 1'b0);
            end
        end
    endtask

    function automatic int rrow();
        return int'($urandom_range(524, 45));
    endfunction

    initial begin
        total    = 0;
        bad      = 0;
        mode_req = 0;
        mode_m   = 0;
        ofs_m    = 0;
        band_ok  = 1'b0;
        bar_ok   = 1'b0;
        bus.MODE = 2'd0;
        bus.HCNT = '0;
        bus.VCNT = '0;
        RST      = 1'b1;

        step(0, 0, 1'b1);
        step(0, 0, 1'b1);

        run_frame(0, -1, 45, 165, 524, -1);
        run_frame(1, -1, 45, rrow(), rrow(), -1);
        run_frame(3, -1, 45, rrow(), rrow(), -1);
        run_frame(2, -1, 45, 77, rrow(), -1);
        run_frame(0, 1, 210, 400, rrow(), -1);
        run_frame(1, -1, 45, 300, rrow(), -1);
        run_frame(3, -1, 100, 300, rrow(), 300);
        run_frame(3, -1, 45, 285, 300, -1);
        run_frame(0, -1, 285, 400, rrow(), -1);

        for (int i = 0; i < 3; i++) begin
            run_frame(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                      rrow(), rrow(), rrow(), -1);
        end

        mode_req = 3;
        for (int i = 0; i < 1030; i++) step(0, 0, 1'b0);
        run_frame(3, -1, 45, rrow(), rrow(), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
